// File: rtl/game_pkg.sv
// Shared types and helpers for the 2048 game controller: grid layout, FSM states,
// move directions and cell accessors.
package game_pkg;

  localparam int unsigned CELL_W    = 4;
  localparam int unsigned NUM_CELLS = 16;
  localparam int unsigned GRID_W    = CELL_W * NUM_CELLS;

  typedef logic [GRID_W-1:0] grid_t;
  typedef logic [CELL_W-1:0] cell_t;

  // Encoding is visible on game_state, so values are fixed explicitly.
  typedef enum logic [2:0] {
    StWelcome = 3'd0,
    StNew     = 3'd1,
    StSpawn   = 3'd2,
    StCheck   = 3'd3,
    StIdle    = 3'd4,
    StMove    = 3'd5,
    StWin     = 3'd6,
    StLose    = 3'd7
  } state_e;

  typedef enum logic [1:0] {
    DirUp    = 2'd0,
    DirDown  = 2'd1,
    DirLeft  = 2'd2,
    DirRight = 2'd3
  } dir_e;

  function automatic cell_t get_cell(grid_t grid, logic [3:0] idx);
    return grid[{idx, 2'b00} +: CELL_W];
  endfunction

  function automatic grid_t set_cell(grid_t grid, logic [3:0] idx, cell_t val);
    grid_t res;
    res = grid;
    res[{idx, 2'b00} +: CELL_W] = val;
    return res;
  endfunction

endpackage

// File: rtl/game_sequencer_if.sv
// Request/done handshake between the game sequencer and the external move engine.
interface game_sequencer_if;
  import game_pkg::*;

  logic        move_req;
  logic [1:0]  move_dir;
  grid_t       move_grid;
  logic        move_done;
  grid_t       move_result;
  logic        move_changed;

  modport master (
    output move_req,
    output move_dir,
    output move_grid,
    input  move_done,
    input  move_result,
    input  move_changed
  );

  modport slave (
    input  move_req,
    input  move_dir,
    input  move_grid,
    output move_done,
    output move_result,
    output move_changed
  );

endinterface

// File: rtl/grid_status.sv
// Combinational summary of a play grid: free space, first free cell, win tile and
// whether any row/column neighbours could still merge.
module grid_status
  import game_pkg::*;
#(
  parameter int unsigned WIN_EXP = 11
) (
  input  grid_t       grid,
  output logic        has_empty,
  output logic [3:0]  first_empty_idx,
  output logic        has_win,
  output logic        can_merge
);

  always_comb begin
    has_empty       = 1'b0;
    first_empty_idx = 4'd0;
    has_win         = 1'b0;
    // Scan high to low so the lowest empty index is the one left standing.
    for (int i = NUM_CELLS - 1; i >= 0; i--) begin
      if (get_cell(grid, 4'(i)) == '0) begin
        has_empty       = 1'b1;
        first_empty_idx = 4'(i);
      end
      if (32'(get_cell(grid, 4'(i))) >= WIN_EXP) begin
        has_win = 1'b1;
      end
    end
  end

  always_comb begin
    can_merge = 1'b0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        // Right neighbour only within the row; no wrap onto the next row.
        if (c < 3) begin
          if (get_cell(grid, 4'(r * 4 + c)) == get_cell(grid, 4'(r * 4 + c + 1))) begin
            can_merge = 1'b1;
          end
        end
        if (r < 3) begin
          if (get_cell(grid, 4'(r * 4 + c)) == get_cell(grid, 4'(r * 4 + c + 4))) begin
            can_merge = 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/game_sequencer.sv
// 2048 game controller: owns the play grid, sequences play and shares the move engine.
// Optional macro GAME_SEQUENCER_SPAWN_FOUR_EN makes every Nth spawned tile a 4.
module game_sequencer
  import game_pkg::*;
#(
  parameter int unsigned WIN_EXP           = 11,
  parameter int unsigned SPAWN_RETRY_MAX   = 16,
  parameter int unsigned SPAWN_FOUR_PERIOD = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [3:0]         lfsr_out,
  input  logic               btn_start,
  input  logic [3:0]         btn_dir,
  input  grid_t              welcome_grid,
  game_sequencer_if.master   move_if,
  output grid_t              display_grid,
  output logic [2:0]         game_state
);

  localparam int unsigned RetryW = $clog2(SPAWN_RETRY_MAX + 1);

  // The spawn counter is 4 bits wide and must be able to reach PERIOD-1.
  if (SPAWN_FOUR_PERIOD < 2 || SPAWN_FOUR_PERIOD > 16) begin : g_bad_period
    $error("SPAWN_FOUR_PERIOD must be in 2..16");
  end
  if (SPAWN_RETRY_MAX < 1) begin : g_bad_retry
    $error("SPAWN_RETRY_MAX must be at least 1");
  end

  state_e              state_q, state_d;
  grid_t               grid_q, grid_d;
  logic [1:0]          pending_q, pending_d;
  logic [RetryW-1:0]   retry_q, retry_d;
  logic                move_req_q, move_req_d;
  logic [1:0]          move_dir_q, move_dir_d;

  logic                spawn_we;
  logic [3:0]          spawn_idx;
  cell_t               spawn_val;

  logic                has_empty;
  logic [3:0]          first_empty_idx;
  logic                has_win;
  logic                can_merge;

  grid_status #(
    .WIN_EXP (WIN_EXP)
  ) u_grid_status (
    .grid            (grid_q),
    .has_empty       (has_empty),
    .first_empty_idx (first_empty_idx),
    .has_win         (has_win),
    .can_merge       (can_merge)
  );

`ifdef GAME_SEQUENCER_SPAWN_FOUR_EN
  logic [3:0] spawn_cnt_q, spawn_cnt_d;

  assign spawn_val = (spawn_cnt_q == 4'(SPAWN_FOUR_PERIOD - 1)) ? 4'd2 : 4'd1;

  always_comb begin
    spawn_cnt_d = spawn_cnt_q;
    if (spawn_we) begin
      spawn_cnt_d = (spawn_cnt_q == 4'(SPAWN_FOUR_PERIOD - 1)) ? 4'd0 : spawn_cnt_q + 4'd1;
    end
  end

  // Deliberately survives NEW/WELCOME; only a hard reset restarts the cadence.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      spawn_cnt_q <= 4'd0;
    end else begin
      spawn_cnt_q <= spawn_cnt_d;
    end
  end
`else
  assign spawn_val = 4'd1;
`endif

  always_comb begin
    state_d    = state_q;
    grid_d     = grid_q;
    pending_d  = pending_q;
    retry_d    = retry_q;
    move_req_d = 1'b0;
    move_dir_d = move_dir_q;
    spawn_we   = 1'b0;
    spawn_idx  = 4'd0;

    unique case (state_q)
      StWelcome: begin
        if (btn_start) state_d = StNew;
      end

      StNew: begin
        grid_d    = '0;
        pending_d = 2'd2;
        retry_d   = '0;
        state_d   = StSpawn;
      end

      StSpawn: begin
        if (!has_empty) begin
          pending_d = 2'd0;
          retry_d   = '0;
          state_d   = StCheck;
        end else if (retry_q == RetryW'(SPAWN_RETRY_MAX)) begin
          spawn_we  = 1'b1;
          spawn_idx = first_empty_idx;
        end else if (get_cell(grid_q, lfsr_out) == '0) begin
          spawn_we  = 1'b1;
          spawn_idx = lfsr_out;
        end else begin
          retry_d = retry_q + 1'b1;
        end

        if (spawn_we) begin
          grid_d    = set_cell(grid_q, spawn_idx, spawn_val);
          retry_d   = '0;
          pending_d = pending_q - 2'd1;
          if (pending_q == 2'd1) state_d = StCheck;
        end
      end

      StCheck: begin
        if (has_win) begin
          state_d = StWin;
        end else if (!has_empty && !can_merge) begin
          state_d = StLose;
        end else begin
          state_d = StIdle;
        end
      end

      StIdle: begin
        if (btn_start) begin
          state_d = StNew;
        end else if (|btn_dir) begin
          move_req_d = 1'b1;
          state_d    = StMove;
          if (btn_dir[0]) begin
            move_dir_d = DirUp;
          end else if (btn_dir[1]) begin
            move_dir_d = DirDown;
          end else if (btn_dir[2]) begin
            move_dir_d = DirLeft;
          end else begin
            move_dir_d = DirRight;
          end
        end
      end

      StMove: begin
        if (move_if.move_done) begin
          if (move_if.move_changed) begin
            grid_d    = move_if.move_result;
            pending_d = 2'd1;
            retry_d   = '0;
            state_d   = StSpawn;
          end else begin
            state_d = StIdle;
          end
        end
      end

      StWin, StLose: begin
        if (btn_start) state_d = StWelcome;
      end

      default: state_d = StWelcome;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StWelcome;
      grid_q     <= '0;
      pending_q  <= 2'd0;
      retry_q    <= '0;
      move_req_q <= 1'b0;
      move_dir_q <= 2'd0;
    end else begin
      state_q    <= state_d;
      grid_q     <= grid_d;
      pending_q  <= pending_d;
      retry_q    <= retry_d;
      move_req_q <= move_req_d;
      move_dir_q <= move_dir_d;
    end
  end

  assign move_if.move_req  = move_req_q;
  assign move_if.move_dir  = move_dir_q;
  assign move_if.move_grid = grid_q;

  assign display_grid = (state_q == StWelcome) ? welcome_grid : grid_q;
  assign game_state   = state_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Bench for game_sequencer: directed scenarios plus random play, checked every cycle
// against a cell-array model of the game rules.
module tb_game_sequencer;
  import game_pkg::*;

  localparam int WIN_E       = 11;
  localparam int RETRY_MAX   = 16;
  localparam int FOUR_PERIOD = 10;

  localparam int S_WELCOME = 0, S_NEW = 1, S_SPAWN = 2, S_CHECK = 3;
  localparam int S_IDLE = 4, S_MOVE = 5, S_WIN = 6, S_LOSE = 7;

  localparam logic [63:0] WELCOME_PIC = 64'h1234_5678_9ABC_DEF0;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  lfsr_out;
  logic        btn_start;
  logic [3:0]  btn_dir;
  logic [63:0] welcome_grid;
  logic [63:0] display_grid;
  logic [2:0]  game_state;

  always #5 clk = ~clk;

  game_sequencer_if mif ();

  game_sequencer #(
    .WIN_EXP           (WIN_E),
    .SPAWN_RETRY_MAX   (RETRY_MAX),
    .SPAWN_FOUR_PERIOD (FOUR_PERIOD)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .lfsr_out     (lfsr_out),
    .btn_start    (btn_start),
    .btn_dir      (btn_dir),
    .welcome_grid (welcome_grid),
    .move_if      (mif.master),
    .display_grid (display_grid),
    .game_state   (game_state)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: game rules over a plain array of exponents.
  int          m_state;
  int unsigned m_cells [16];
  int          m_pending;
  int          m_retry;
  int          m_spawned;
  bit          m_req;
  int          m_dir;
  bit          m_valid = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [63:0] m_grid();
    logic [63:0] g = '0;
    for (int i = 0; i < 16; i++) g[4*i +: 4] = m_cells[i][3:0];
    return g;
  endfunction

  function automatic int n_empty();
    int n = 0;
    for (int i = 0; i < 16; i++) if (m_cells[i] == 0) n++;
    return n;
  endfunction

  function automatic int first_empty();
    for (int i = 0; i < 16; i++) if (m_cells[i] == 0) return i;
    return 0;
  endfunction

  function automatic bit any_win();
    for (int i = 0; i < 16; i++) if (m_cells[i] >= WIN_E) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit any_pair();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        if (c < 3 && m_cells[r*4+c] == m_cells[r*4+c+1]) return 1'b1;
        if (r < 3 && m_cells[r*4+c] == m_cells[(r+1)*4+c]) return 1'b1;
      end
    return 1'b0;
  endfunction

  task automatic m_place(input int idx);
    int unsigned v = 1;
`ifdef GAME_SEQUENCER_SPAWN_FOUR_EN
    if ((m_spawned + 1) % FOUR_PERIOD == 0) v = 2;
`endif
    m_spawned++;
    m_cells[idx] = v;
    m_retry = 0;
    m_pending--;
    if (m_pending == 0) m_state = S_CHECK;
  endtask

  task automatic m_step();
    if (!rst_n) begin
      m_state = S_WELCOME;
      foreach (m_cells[i]) m_cells[i] = 0;
      m_pending = 0; m_retry = 0; m_spawned = 0; m_req = 0; m_dir = 0;
      m_valid = 1'b1;
      return;
    end
    if (!m_valid) return;
    m_req = 0;
    case (m_state)
      S_WELCOME: if (btn_start) m_state = S_NEW;
      S_NEW: begin
        foreach (m_cells[i]) m_cells[i] = 0;
        m_pending = 2; m_retry = 0; m_state = S_SPAWN;
      end
      S_SPAWN: begin
        if (n_empty() == 0) begin
          m_pending = 0; m_state = S_CHECK;
        end else if (m_retry == RETRY_MAX) m_place(first_empty());
        else if (m_cells[lfsr_out] == 0) m_place(int'(lfsr_out));
        else m_retry++;
      end
      S_CHECK: begin
        if (any_win()) m_state = S_WIN;
        else if (n_empty() == 0 && !any_pair()) m_state = S_LOSE;
        else m_state = S_IDLE;
      end
      S_IDLE: begin
        if (btn_start) m_state = S_NEW;
        else if (btn_dir != 0) begin
          m_req = 1;
          for (int b = 3; b >= 0; b--) if (btn_dir[b]) m_dir = b;
          m_state = S_MOVE;
        end
      end
      S_MOVE: begin
        if (mif.move_done) begin
          if (mif.move_changed) begin
            for (int i = 0; i < 16; i++) m_cells[i] = mif.move_result[4*i +: 4];
            m_pending = 1; m_state = S_SPAWN;
          end else m_state = S_IDLE;
        end
      end
      default: if (btn_start) m_state = S_WELCOME;
    endcase
  endtask

  task automatic compare_all();
    chk("game_state", 64'(game_state), 64'(m_state));
    chk("move_req", 64'(mif.move_req), 64'(m_req));
    chk("move_dir", 64'(mif.move_dir), 64'(m_dir));
    chk("move_grid", mif.move_grid, m_grid());
    chk("display_grid", display_grid, (m_state == S_WELCOME) ? welcome_grid : m_grid());
  endtask

  // One clock: inputs already set at the falling edge; compare, advance model, clear pulses.
  task automatic cyc();
    #1;
    if (m_valid) compare_all();
    m_step();
    @(negedge clk);
    btn_start     = 1'b0;
    btn_dir       = 4'd0;
    mif.move_done = 1'b0;
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  function automatic logic [63:0] checker_grid(input bit hole15);
    logic [63:0] g = '0;
    for (int i = 0; i < 16; i++) g[4*i +: 4] = (((i / 4) + (i % 4)) % 2 == 0) ? 4'd2 : 4'd1;
    if (hole15) g[60 +: 4] = 4'd0;
    return g;
  endfunction

  function automatic logic [63:0] rand_grid();
    logic [63:0] g = '0;
    for (int i = 0; i < 16; i++) begin
      int r = $urandom_range(0, 9);
      g[4*i +: 4] = (r < 4) ? 4'd0 : 4'(r - 3);
    end
    if ($urandom_range(0, 40) == 0) g[4*$urandom_range(0, 15) +: 4] = 4'd11;
    return g;
  endfunction

  task automatic start_game(input logic [3:0] l1, input logic [3:0] l2);
    btn_start = 1'b1; cyc();
    cyc();
    lfsr_out = l1; cyc();
    lfsr_out = l2; cyc();
    cyc();
  endtask

  task automatic move(input logic [3:0] dir, input bit changed, input logic [63:0] res);
    btn_dir = dir; cyc();
    cyc();
    mif.move_done = 1'b1; mif.move_changed = changed; mif.move_result = res; cyc();
  endtask

  initial begin
    rst_n = 1'b0; lfsr_out = 4'd0; btn_start = 1'b0; btn_dir = 4'd0;
    welcome_grid = WELCOME_PIC;
    mif.move_done = 1'b0; mif.move_changed = 1'b0; mif.move_result = '0;
    @(negedge clk);
    cycles(2);
    rst_n = 1'b1;

    // Reset state and welcome mux.
    chk("rst_state", 64'(game_state), 64'd0);
    chk("rst_grid", mif.move_grid, 64'd0);
    chk("welcome_disp", display_grid, WELCOME_PIC);

    // New game with lfsr 5,5,9.
    btn_start = 1'b1; cyc();
    cyc();
    lfsr_out = 4'd5; cyc();
    lfsr_out = 4'd5; cyc();
    lfsr_out = 4'd9; cyc();
    cyc();
    chk("new_state", 64'(game_state), 64'd4);
    chk("new_grid", mif.move_grid, 64'h0000_0010_0010_0000);
    chk("new_disp", display_grid, 64'h0000_0010_0010_0000);

    // Up wins over down; unchanged move returns to IDLE without spawn.
    btn_dir = 4'b0101; cyc();
    chk("req_pulse", 64'(mif.move_req), 64'd1);
    chk("req_dir", 64'(mif.move_dir), 64'd0);
    btn_dir = 4'b1000; cyc();
    chk("req_once", 64'(mif.move_req), 64'd0);
    cyc();
    mif.move_done = 1'b1; mif.move_changed = 1'b0; mif.move_result = 64'hFFFF; cyc();
    chk("nochg_state", 64'(game_state), 64'd4);
    chk("nochg_grid", mif.move_grid, 64'h0000_0010_0010_0000);

    // Changed move bringing a 2048 tile: one spawn, then WIN.
    btn_dir = 4'b1100; cyc();
    chk("left_dir", 64'(mif.move_dir), 64'd2);
    cyc();
    mif.move_done = 1'b1; mif.move_changed = 1'b1;
    mif.move_result = 64'h0000_0010_0010_000B; cyc();
    lfsr_out = 4'd0; cyc();
    lfsr_out = 4'd2; cyc();
    cyc();
    chk("win_state", 64'(game_state), 64'd6);
    chk("win_grid", mif.move_grid, 64'h0000_0010_0010_010B);
    btn_dir = 4'b0001; cyc();
    chk("win_ignore", 64'(mif.move_req), 64'd0);
    btn_start = 1'b1; cyc();
    chk("win_to_welcome", 64'(game_state), 64'd0);

    // Fallback spawn after 16 misses fills cell 15, which pairs with cell 14.
    start_game(4'd1, 4'd2);
    move(4'b0001, 1'b1, checker_grid(1'b1));
    lfsr_out = 4'd0;
    cycles(16);
    chk("retry_wait", 64'(game_state), 64'd2);
    cyc();
    chk("fallback_cell", 64'(mif.move_grid[60 +: 4]), 64'd1);
    cyc();
    chk("fallback_idle", 64'(game_state), 64'd4);

    // Full grid with no equal neighbours: spawn skipped, LOSE.
    move(4'b0010, 1'b1, checker_grid(1'b0));
    cycles(2);
    chk("lose_state", 64'(game_state), 64'd7);
    chk("lose_grid", mif.move_grid, checker_grid(1'b0));
    btn_start = 1'b1; cyc();

    // Reset while MOVE, then a stale move_done.
    start_game(4'd3, 4'd4);
    btn_dir = 4'b0010; cyc();
    rst_n = 1'b0; cyc();
    rst_n = 1'b1;
    mif.move_done = 1'b1; mif.move_changed = 1'b1; mif.move_result = 64'h1111; cyc();
    chk("rst_move_state", 64'(game_state), 64'd0);
    chk("rst_move_grid", mif.move_grid, 64'd0);

    // Ten spawns after reset, the tenth landing on cell 0.
    start_game(4'd0, 4'd1);
    for (int k = 3; k <= 10; k++) begin
      move(4'b0001, 1'b1, 64'd0);
      lfsr_out = 4'd0; cyc();
      cyc();
    end
`ifdef GAME_SEQUENCER_SPAWN_FOUR_EN
    chk("tenth_spawn", 64'(mif.move_grid[3:0]), 64'd2);
`else
    chk("tenth_spawn", 64'(mif.move_grid[3:0]), 64'd1);
`endif

    // Random play.
    for (int i = 0; i < 3000; i++) begin
      lfsr_out = 4'($urandom);
      rst_n = ($urandom_range(0, 499) != 0);
      if ($urandom_range(0, 39) == 0) btn_start = 1'b1;
      else if ($urandom_range(0, 3) == 0) btn_dir = 4'($urandom_range(1, 15));
      if ((m_state == S_MOVE && !m_req && $urandom_range(0, 2) == 0) ||
          $urandom_range(0, 60) == 0) begin
        mif.move_done    = 1'b1;
        mif.move_changed = ($urandom_range(0, 3) != 0);
        mif.move_result  = ($urandom_range(0, 15) == 0) ? checker_grid(1'b0) : rand_grid();
      end
      cyc();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
